// File: rtl/sim_host_if.sv
// Simulation host interface: console byte FIFO with paced drain, tohost pass/fail capture.
// Optional macro SIM_HOST_CYCLE_CNT_EN adds a 64-bit cycle counter at CONSOLE_ADDR+8/+12.
module sim_host_if #(
  parameter int unsigned FIFO_DEPTH   = 16,
  parameter int unsigned TX_DIV       = 4,
  parameter logic [31:0] CONSOLE_ADDR = 32'h9a10_0000,
  parameter logic [31:0] TOHOST_ADDR  = 32'h8000_1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_req_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        char_valid_o,
  output logic [7:0]  char_data_o,
  input  logic        char_ready_i,
  output logic        tohost_valid_o,
  output logic [30:0] tohost_code_o,
  output logic        pass_o,
  output logic        fail_o
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned GAP_W = (TX_DIV > 1) ? $clog2(TX_DIV) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD    = GAP_W'(TX_DIV - 1);
  localparam logic [CNT_W-1:0] DEPTH_CNT   = CNT_W'(FIFO_DEPTH);
  localparam logic [31:0]      STATUS_ADDR = CONSOLE_ADDR + 32'd4;

  typedef enum logic [1:0] {ST_IDLE, ST_GAP, ST_SEND} state_t;

  state_t             state, state_nxt;
  logic [GAP_W-1:0]   gap_cnt, gap_nxt;
  logic [7:0]         mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   count;
  logic               fifo_full, fifo_empty;
  logic               console_wr, push, pop, tohost_wr;
  logic [31:0]        rd_val;
  logic               unused_be;

  assign unused_be  = ^data_be_i[3:1];
  assign fifo_full  = (count == DEPTH_CNT);
  assign fifo_empty = (count == '0);

  // Full comes from the registered count, so a same-cycle pop never frees a slot early.
  assign console_wr = data_we_i && (data_addr_i == CONSOLE_ADDR);
  assign data_gnt_o = data_req_i && !(console_wr && fifo_full);
  assign push       = data_gnt_o && console_wr && data_be_i[0];
  assign pop        = (state == ST_SEND) && char_ready_i;
  assign tohost_wr  = data_gnt_o && data_we_i && (data_addr_i == TOHOST_ADDR) &&
                      (data_wdata_i != 32'd0) && !pass_o && !fail_o;

  // Byte FIFO storage and pointers
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= data_wdata_i[7:0];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef SIM_HOST_CYCLE_CNT_EN
  logic [63:0] cycle_cnt;

  always_ff @(posedge clk) begin
    if (!reset) cycle_cnt <= '0;
    else        cycle_cnt <= cycle_cnt + 64'd1;
  end
`endif

  // Drain FSM: state register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= ST_IDLE;
      gap_cnt <= '0;
    end else begin
      state   <= state_nxt;
      gap_cnt <= gap_nxt;
    end
  end

  // Drain FSM: next state; a byte pushed during the final pop keeps the drain going
  always_comb begin
    state_nxt = state;
    gap_nxt   = gap_cnt;
    unique case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          state_nxt = ST_GAP;
          gap_nxt   = GAP_LOAD;
        end
      end
      ST_GAP: begin
        if (gap_cnt == '0) state_nxt = ST_SEND;
        else               gap_nxt   = gap_cnt - GAP_W'(1);
      end
      ST_SEND: begin
        if (char_ready_i) begin
          if ((count > CNT_W'(1)) || push) begin
            state_nxt = ST_GAP;
            gap_nxt   = GAP_LOAD;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Drain FSM: outputs
  always_comb begin
    char_valid_o = (state == ST_SEND);
    char_data_o  = mem[rd_ptr];
  end

  // Read decode
  always_comb begin
    rd_val = '0;
    if (data_addr_i == STATUS_ADDR)
      rd_val = {16'b0, 8'(count), 6'b0, fifo_full, fifo_empty};
`ifdef SIM_HOST_CYCLE_CNT_EN
    else if (data_addr_i == CONSOLE_ADDR + 32'd8)
      rd_val = cycle_cnt[31:0];
    else if (data_addr_i == CONSOLE_ADDR + 32'd12)
      rd_val = cycle_cnt[63:32];
`endif
  end

  // Response channel
  always_ff @(posedge clk) begin
    if (!reset) begin
      data_rvalid_o <= 1'b0;
      data_rdata_o  <= '0;
    end else begin
      data_rvalid_o <= data_gnt_o;
      data_rdata_o  <= (data_gnt_o && !data_we_i) ? rd_val : 32'd0;
    end
  end

  // Tohost result capture: first nonzero write wins
  always_ff @(posedge clk) begin
    if (!reset) begin
      tohost_valid_o <= 1'b0;
      tohost_code_o  <= '0;
      pass_o         <= 1'b0;
      fail_o         <= 1'b0;
    end else begin
      tohost_valid_o <= tohost_wr;
      if (tohost_wr) begin
        if (data_wdata_i == 32'd1) begin
          pass_o <= 1'b1;
        end else begin
          fail_o        <= 1'b1;
          tohost_code_o <= data_wdata_i[31:1];
        end
      end
    end
  end

endmodule

// File: tb/tb_sim_host_if.sv
// Self-checking bench for sim_host_if: directed scenarios plus randomized console traffic
// checked against a queue-based model of the console FIFO and tohost rules.
module tb_sim_host_if;

  localparam int unsigned FIFO_DEPTH   = 16;
  localparam int unsigned TX_DIV       = 4;
  localparam logic [31:0] CONSOLE_ADDR = 32'h9a10_0000;
  localparam logic [31:0] TOHOST_ADDR  = 32'h8000_1000;
  localparam logic [31:0] STATUS_ADDR  = CONSOLE_ADDR + 32'd4;
  localparam int unsigned TIMEOUT      = 2000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        data_req_i = 1'b0;
  logic        data_we_i = 1'b0;
  logic [3:0]  data_be_i = 4'h0;
  logic [31:0] data_addr_i = 32'h0;
  logic [31:0] data_wdata_i = 32'h0;
  logic        data_gnt_o, data_rvalid_o;
  logic [31:0] data_rdata_o;
  logic        char_valid_o;
  logic [7:0]  char_data_o;
  logic        char_ready_i = 1'b0;
  logic        tohost_valid_o;
  logic [30:0] tohost_code_o;
  logic        pass_o, fail_o;

  int unsigned n_checks = 0;
  int unsigned n_fail = 0;
  int unsigned rdy_mode = 0;   // 0: sink stalls, 1: sink always ready, 2: random
  logic [7:0]  model_q[$];
  logic [63:0] cyc_model = '0;
  logic        hold = 1'b0;
  logic [7:0]  hold_data = 8'h0;

  sim_host_if #(
    .FIFO_DEPTH(FIFO_DEPTH), .TX_DIV(TX_DIV),
    .CONSOLE_ADDR(CONSOLE_ADDR), .TOHOST_ADDR(TOHOST_ADDR)
  ) dut (
    .clk(clk), .reset(reset),
    .data_req_i(data_req_i), .data_we_i(data_we_i), .data_be_i(data_be_i),
    .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i),
    .data_gnt_o(data_gnt_o), .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o),
    .char_valid_o(char_valid_o), .char_data_o(char_data_o), .char_ready_i(char_ready_i),
    .tohost_valid_o(tohost_valid_o), .tohost_code_o(tohost_code_o),
    .pass_o(pass_o), .fail_o(fail_o)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc_model <= !reset ? 64'd0 : cyc_model + 64'd1;

  initial begin
    forever begin
      @(posedge clk);
      #2;
      char_ready_i = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : (rdy_mode == 1);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_read(input logic [31:0] addr);
    int unsigned n = model_q.size();
    if (addr == STATUS_ADDR) return {16'h0, 8'(n), 6'h0, n == FIFO_DEPTH, n == 0};
`ifdef SIM_HOST_CYCLE_CNT_EN
    if (addr == CONSOLE_ADDR + 32'd8)  return cyc_model[31:0];
    if (addr == CONSOLE_ADDR + 32'd12) return cyc_model[63:32];
`endif
    return 32'h0;
  endfunction

  // Console sink monitor: bytes must leave in push order and stay stable while stalled
  always @(negedge clk) begin
    if (!reset) begin
      hold = 1'b0;
    end else begin
      if (hold) begin
        chk("char_hold_valid", char_valid_o, 1'b1);
        chk("char_hold_data", char_data_o, hold_data);
      end
      if (char_valid_o) begin
        n_checks++;
        assert (model_q.size() != 0) else begin
          n_fail++;
          $error("FAIL char_spurious observed=%0h expected=no byte", char_data_o);
        end
        if (model_q.size() != 0) chk("char_data", char_data_o, model_q[0]);
        if (char_ready_i) begin
          if (model_q.size() != 0) void'(model_q.pop_front());
          hold = 1'b0;
        end else begin
          hold = 1'b1;
          hold_data = char_data_o;
        end
      end else begin
        hold = 1'b0;
      end
    end
  end

  // One bus transaction; retries while not granted, checks gnt, rvalid and read data
  task automatic bus(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                     input logic [3:0] be, output logic [31:0] rd);
    logic granted = 1'b0;
    logic [31:0] exp_rd = '0;
    int unsigned waited = 0;
    data_req_i = 1'b1; data_we_i = we; data_addr_i = addr; data_wdata_i = wd; data_be_i = be;
    while (!granted && waited < TIMEOUT) begin
      #1;
      chk("gnt", data_gnt_o, !(we && addr == CONSOLE_ADDR && model_q.size() == FIFO_DEPTH));
      granted = data_gnt_o;
      exp_rd = ref_read(addr);
      if (granted && we && addr == CONSOLE_ADDR && be[0]) model_q.push_back(wd[7:0]);
      @(posedge clk); #1;
      if (!granted) begin
        chk("rvalid_no_gnt", data_rvalid_o, 1'b0);
        waited++;
      end
    end
    data_req_i = 1'b0; data_we_i = 1'b0;
    chk("bus_granted", granted, 1'b1);
    chk("rvalid", data_rvalid_o, 1'b1);
    if (!we) chk("rdata", data_rdata_o, exp_rd);
    rd = data_rdata_o;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    model_q.delete();
  endtask

  task automatic drain();
    int unsigned t = 0;
    rdy_mode = 1;
    while ((model_q.size() != 0 || char_valid_o) && t < TIMEOUT) begin
      @(posedge clk); #1; t++;
    end
    chk("drain_done", model_q.size(), 0);
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    logic [31:0] rd, r0;
    int unsigned lat, nv, op;
    logic [31:0] addr;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rvalid", data_rvalid_o, 1'b0);
    chk("rst_rdata", data_rdata_o, 32'h0);
    chk("rst_char_valid", char_valid_o, 1'b0);
    chk("rst_tohost_valid", tohost_valid_o, 1'b0);
    chk("rst_code", tohost_code_o, 31'h0);
    chk("rst_pass", pass_o, 1'b0);
    chk("rst_fail", fail_o, 1'b0);
    chk("rst_gnt_idle", data_gnt_o, 1'b0);
    reset = 1'b1;
    idle(1);
    bus(1'b0, STATUS_ADDR, 32'h0, 4'h0, rd);
    chk("status_empty", rd, 32'h0000_0001);

    // Single console byte with its pacing gap
    rdy_mode = 1;
    bus(1'b1, CONSOLE_ADDR, 32'h0000_0041, 4'h1, rd);
    lat = 1;
    while (!char_valid_o && lat < 100) begin @(posedge clk); #1; lat++; end
    chk("tx_latency", lat, TX_DIV + 2);
    chk("tx_byte", char_data_o, 8'h41);
    nv = 0;
    repeat (20) begin @(posedge clk); #1; nv += char_valid_o; end
    chk("single_byte", nv, 0);
    bus(1'b1, CONSOLE_ADDR, 32'h0000_0055, 4'hE, rd);
    idle(TX_DIV + 4);
    chk("be0_clear_ignored", char_valid_o, 1'b0);

    // Fill to full, overflow write waits for a pop
    do_reset();
    rdy_mode = 0;
    for (int i = 0; i < 16; i++) bus(1'b1, CONSOLE_ADDR, 32'h100 | i, 4'h1, rd);
    bus(1'b0, STATUS_ADDR, 32'h0, 4'h0, rd);
    chk("status_full", rd, 32'h0000_1002);
    data_req_i = 1'b1; data_we_i = 1'b1; data_addr_i = CONSOLE_ADDR;
    data_wdata_i = 32'h0000_00A5; data_be_i = 4'hF;
    repeat (3) begin
      #1; chk("gnt_full", data_gnt_o, 1'b0);
      @(posedge clk); #1; chk("rvalid_full", data_rvalid_o, 1'b0);
    end
    rdy_mode = 1;
    #1; chk("gnt_full_pop", data_gnt_o, 1'b0);
    @(posedge clk); #1;
    rdy_mode = 0;
    #1; chk("gnt_after_pop", data_gnt_o, 1'b1);
    model_q.push_back(8'hA5);
    @(posedge clk); #1;
    data_req_i = 1'b0; data_we_i = 1'b0;
    chk("rvalid_after_pop", data_rvalid_o, 1'b1);
    drain();
    bus(1'b0, STATUS_ADDR, 32'h0, 4'h0, rd);
    chk("status_drained", rd, 32'h0000_0001);

    // Reset while sending, with a request in the reset cycle
    rdy_mode = 0;
    for (int i = 0; i < 3; i++) bus(1'b1, CONSOLE_ADDR, 32'h30 + i, 4'h1, rd);
    lat = 0;
    while (!char_valid_o && lat < 100) begin @(posedge clk); #1; lat++; end
    chk("send_before_reset", char_valid_o, 1'b1);
    data_req_i = 1'b1; data_we_i = 1'b0; data_addr_i = STATUS_ADDR;
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1; data_req_i = 1'b0; model_q.delete();
    chk("reset_char_valid", char_valid_o, 1'b0);
    chk("reset_no_rvalid", data_rvalid_o, 1'b0);
    bus(1'b0, STATUS_ADDR, 32'h0, 4'h0, rd);
    chk("status_after_reset", rd, 32'h0000_0001);

    // Tohost pass, then a later failure code is ignored
    bus(1'b1, TOHOST_ADDR, 32'd1, 4'hF, rd);
    chk("pass_pulse", tohost_valid_o, 1'b1);
    chk("pass_set", pass_o, 1'b1);
    chk("pass_fail_clear", fail_o, 1'b0);
    idle(1);
    chk("pass_pulse_end", tohost_valid_o, 1'b0);
    bus(1'b1, TOHOST_ADDR, 32'd7, 4'hF, rd);
    chk("late_fail_pulse", tohost_valid_o, 1'b0);
    chk("late_fail_ignored", fail_o, 1'b0);
    chk("late_code_ignored", tohost_code_o, 31'h0);
    bus(1'b0, TOHOST_ADDR, 32'h0, 4'h0, rd);

    // Tohost zero ignored, then failure code latched
    do_reset();
    chk("pass_cleared", pass_o, 1'b0);
    bus(1'b1, TOHOST_ADDR, 32'd0, 4'hF, rd);
    chk("zero_no_pulse", tohost_valid_o, 1'b0);
    chk("zero_no_fail", fail_o, 1'b0);
    r0 = 32'h15;
    bus(1'b1, TOHOST_ADDR, r0, 4'hF, rd);
    chk("fail_pulse", tohost_valid_o, 1'b1);
    chk("fail_set", fail_o, 1'b1);
    chk("fail_code", tohost_code_o, r0 >> 1);
    bus(1'b1, TOHOST_ADDR, 32'd1, 4'hF, rd);
    chk("late_pass_ignored", pass_o, 1'b0);

`ifdef SIM_HOST_CYCLE_CNT_EN
    bus(1'b0, CONSOLE_ADDR + 32'd8, 32'h0, 4'h0, r0);
    idle(9);
    bus(1'b0, CONSOLE_ADDR + 32'd8, 32'h0, 4'h0, rd);
    chk("cycle_delta", rd - r0, 32'd10);
`endif

    // Randomized console, status and unmapped traffic with a random sink
    do_reset();
    rdy_mode = 2;
    for (int k = 0; k < 300; k++) begin
      op = $urandom_range(0, 9);
      if (op <= 5) begin
        bus(1'b1, CONSOLE_ADDR, $urandom, 4'($urandom_range(0, 15)), rd);
      end else if (op == 6) begin
        bus(1'b0, STATUS_ADDR, 32'h0, 4'h0, rd);
      end else if (op == 7) begin
        case ($urandom_range(0, 4))
          0:       addr = CONSOLE_ADDR;
          1:       addr = TOHOST_ADDR;
          2:       addr = CONSOLE_ADDR + 32'd8;
          3:       addr = CONSOLE_ADDR + 32'd12;
          default: addr = 32'h0000_2000 + ($urandom & 32'h0000_0FF0);
        endcase
        bus(1'b0, addr, 32'h0, 4'h0, rd);
      end else if (op == 8) begin
        bus(1'b1, 32'h0000_2000 + ($urandom & 32'h0000_0FF0), $urandom, 4'hF, rd);
      end else begin
        idle($urandom_range(1, 3));
      end
    end
    drain();
    bus(1'b0, STATUS_ADDR, 32'h0, 4'h0, rd);
    chk("status_final", rd, 32'h0000_0001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sim_host_if.md
SIM_HOST_IF -- requirements
Module: sim_host_if

Interface
REQ-001 Parameter FIFO_DEPTH, 16, console byte FIFO depth; power of two, 2..256.
REQ-002 Parameter TX_DIV, 4, idle cycles between console bytes; minimum 1.
REQ-003 Parameter CONSOLE_ADDR, 32'h9a100000, console TX byte address; STATUS register at CONSOLE_ADDR+4.
REQ-004 Parameter TOHOST_ADDR, 32'h80001000, tohost word address.
REQ-005 Clocking and reset: reset reset, synchronous, active-low; clock clk.
REQ-006 clk  in  1  clock.
REQ-007 reset  in  1  synchronous active-low reset.
REQ-008 data_req_i  in  1  core data request.
REQ-009 data_we_i  in  1  write enable.
REQ-010 data_be_i  in  4  byte enables.
REQ-011 data_addr_i  in  32  word address.
REQ-012 data_wdata_i  in  32  write data.
REQ-013 data_gnt_o  out  1  request accepted.
REQ-014 data_rvalid_o  out  1  response valid.
REQ-015 data_rdata_o  out  32  read data.
REQ-016 char_valid_o  out  1  console byte offered.
REQ-017 char_data_o  out  8  console byte.
REQ-018 char_ready_i  in  1  console sink accepts byte.
REQ-019 tohost_valid_o  out  1  one-cycle pulse on first nonzero tohost write.
REQ-020 tohost_code_o  out  31  failure code (wdata>>1).
REQ-021 pass_o  out  1  sticky pass.
REQ-022 fail_o  out  1  sticky fail.

Function
REQ-023 data_gnt_o is combinational: equals data_req_i, except 0 for a console write while the FIFO is full.
REQ-024 data_rvalid_o is asserted exactly one cycle after each granted request, reads and writes.
REQ-025 Read data comes from a register and is valid together with data_rvalid_o; STATUS = {16'b0, count[7:0], 6'b0, full, empty}; all other addresses, including console and tohost, read 0.
REQ-026 A granted write to CONSOLE_ADDR with data_be_i[0]=1 pushes data_wdata_i[7:0]; with be[0]=0 it is granted and ignored.
REQ-027 Full is taken from the registered count; a pop in the same cycle does not allow a push into a full FIFO.
REQ-028 Simultaneous push and pop when not full and not empty leaves the count unchanged; read/write pointers wrap modulo FIFO_DEPTH.
REQ-029 Drain FSM states: IDLE, GAP, SEND.
REQ-030 IDLE->GAP when the FIFO is non-empty; the gap counter is loaded with TX_DIV-1.
REQ-031 GAP decrements each cycle; GAP->SEND when the counter is 0.
REQ-032 In SEND, char_valid_o=1 and char_data_o=head; the byte is held stable until char_ready_i.
REQ-033 SEND with char_ready_i: pop, then go to GAP if more bytes remain, otherwise to IDLE.
REQ-034 A granted write of a nonzero value to TOHOST_ADDR while pass_o=fail_o=0 takes effect as follows: value 1 sets pass_o; any other value sets fail_o and latches tohost_code_o = wdata[31:1].
REQ-035 tohost_valid_o pulses for one cycle, the cycle after the grant.
REQ-036 Tohost writes of 0, and any tohost write after pass or fail is set, are ignored (first result wins).
REQ-037 Writes to unmapped addresses are granted, acknowledged and discarded.

Reset
REQ-038 On reset=0 at a clk edge:
  - FIFO is emptied and the FSM goes to IDLE.
  - data_rvalid_o, char_valid_o, tohost_valid_o, pass_o and fail_o are 0.
  - data_rdata_o and tohost_code_o are 0; the gap counter is 0.
REQ-039 Reset mid-SEND or mid-request drops the pending byte and response; no rvalid is issued for a request granted in the reset cycle.

Configuration
REQ-040 Macro SIM_HOST_CYCLE_CNT_EN defined: a 64-bit free-running cycle counter, cleared by reset and incremented every non-reset cycle, is readable at CONSOLE_ADDR+8 (low word) and CONSOLE_ADDR+12 (high word).
REQ-041 SIM_HOST_CYCLE_CNT_EN undefined: no counter logic; those addresses read 0.

Verification
REQ-042 Write 0x41 to CONSOLE_ADDR with char_ready_i=1 -> gnt same cycle, rvalid +1, char_valid_o with 0x41 after the TX_DIV gap, a single byte.
REQ-043 17 back-to-back console writes with char_ready_i=0 -> 16 granted, 17th gnt=0 until char_ready_i=1 frees an entry; STATUS reads 0x1002 when full.
REQ-044 Write 1 to TOHOST_ADDR -> tohost_valid_o pulse, pass_o=1; a subsequent write of 7 leaves fail_o=0.
REQ-045 Write 0x15 to TOHOST_ADDR -> fail_o=1, tohost_code_o=10.
REQ-046 Assert reset during SEND with 3 bytes queued -> char_valid_o=0 next cycle; STATUS reads 0x0001.
REQ-047 With SIM_HOST_CYCLE_CNT_EN defined, read CONSOLE_ADDR+8 twice 10 cycles apart -> values differ by 10.
